// File: rtl/matrix_mac_sequencer.sv
`default_nettype none
// ============================================================================
// matrix_mac_sequencer : walks i/j/k over C = A x B, one MAC per cycle, and
// writes each finished C[i][j]. Optional macro: MATMUL_SATURATE_EN (clamp).
// Revision: 1.0
// ============================================================================
module matrix_mac_sequencer #(
  parameter int AROWS     = 3,
  parameter int ACOLUMNS  = 3,
  parameter int BCOLUMNS  = 3,
  parameter int WIDTH_BIT = 32,
  parameter int ACC_WIDTH = 72
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        hold,
  output logic        [WIDTH_BIT-1:0] i,
  output logic        [WIDTH_BIT-1:0] j,
  output logic        [WIDTH_BIT-1:0] k,
  input  logic signed [WIDTH_BIT-1:0] Aik,
  input  logic signed [WIDTH_BIT-1:0] Bkj,
  output logic                        ena,
  output logic                        busy,
  output logic                        c_wr_en,
  output logic        [WIDTH_BIT-1:0] c_row,
  output logic        [WIDTH_BIT-1:0] c_col,
  output logic signed [WIDTH_BIT-1:0] c_data,
  output logic                        done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH_BIT-1:0] K_LAST = WIDTH_BIT'(ACOLUMNS - 1);
  localparam logic [WIDTH_BIT-1:0] J_LAST = WIDTH_BIT'(BCOLUMNS - 1);
  localparam logic [WIDTH_BIT-1:0] I_LAST = WIDTH_BIT'(AROWS - 1);
  localparam logic [WIDTH_BIT-1:0] ONE    = WIDTH_BIT'(1);

  state_t                        state_q, state_d;
  logic        [WIDTH_BIT-1:0]   i_q, i_d;
  logic        [WIDTH_BIT-1:0]   j_q, j_d;
  logic        [WIDTH_BIT-1:0]   k_q, k_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          c_wr_en_q, c_wr_en_d;
  logic        [WIDTH_BIT-1:0]   c_row_q, c_row_d;
  logic        [WIDTH_BIT-1:0]   c_col_q, c_col_d;
  logic signed [WIDTH_BIT-1:0]   c_data_q, c_data_d;
  logic                          done_q, done_d;

  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [WIDTH_BIT-1:0]   fmt_val;

  // Operands are widened first so the product is the full signed 2*WIDTH_BIT result.
  assign prod     = (2*WIDTH_BIT)'(Aik) * (2*WIDTH_BIT)'(Bkj);
  assign prod_ext = ACC_WIDTH'(prod);
  assign sum      = acc_q + prod_ext;

`ifdef MATMUL_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-WIDTH_BIT+1){1'b0}}, {(WIDTH_BIT-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-WIDTH_BIT+1){1'b1}}, {(WIDTH_BIT-1){1'b0}}};

  always_comb begin
    fmt_val = sum[WIDTH_BIT-1:0];
    if (sum > SAT_MAX) begin
      fmt_val = {1'b0, {(WIDTH_BIT-1){1'b1}}};
    end else if (sum < SAT_MIN) begin
      fmt_val = {1'b1, {(WIDTH_BIT-1){1'b0}}};
    end
  end
`else
  always_comb begin
    fmt_val = sum[WIDTH_BIT-1:0];
  end
`endif

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    c_wr_en_d = 1'b0;
    c_row_d   = c_row_q;
    c_col_d   = c_col_q;
    c_data_d  = c_data_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          if (k_q != K_LAST) begin
            acc_d = sum;
            k_d   = k_q + ONE;
          end else begin
            c_data_d  = fmt_val;
            c_row_d   = i_q;
            c_col_d   = j_q;
            c_wr_en_d = 1'b1;
            acc_d     = '0;
            k_d       = '0;
            if (j_q != J_LAST) begin
              j_d = j_q + ONE;
            end else begin
              j_d = '0;
              if (i_q == I_LAST) begin
                // Last element: report done alongside its write and return to IDLE.
                done_d  = 1'b1;
                state_d = ST_IDLE;
                i_d     = '0;
              end else begin
                i_d = i_q + ONE;
              end
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      c_wr_en_q <= 1'b0;
      c_row_q   <= '0;
      c_col_q   <= '0;
      c_data_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      c_wr_en_q <= c_wr_en_d;
      c_row_q   <= c_row_d;
      c_col_q   <= c_col_d;
      c_data_q  <= c_data_d;
      done_q    <= done_d;
    end
  end

  assign i       = i_q;
  assign j       = j_q;
  assign k       = k_q;
  assign busy    = (state_q == ST_RUN);
  assign ena     = busy & ~hold;
  assign c_wr_en = c_wr_en_q;
  assign c_row   = c_row_q;
  assign c_col   = c_col_q;
  assign c_data  = c_data_q;
  assign done    = done_q;

endmodule
`default_nettype wire
